vga_scene_timing_ctrl: RTL

- Central timing and sequencing controller for the demoscene VGA/audio datapath.
- Generates 640x480@60 raster counters, HSYNC/VSYNC and display-enable, delayed to match the pixel pipeline.
- Synchronises the scene-select (ui_in[1:0]) and audio-select (ui_in[4:3]) pins and commits them only at frame boundaries, so no frame ever mixes two scenes.
- Provides a frame counter for animation and audio sequencing; sits between the top-level pins and the pattern/audio generators.

---
 rtl/vga_scene_timing_ctrl_pkg.sv | 34 +++
 rtl/vga_scene_timing_ctrl_if.sv | 31 +++
 rtl/vga_scene_timing_ctrl_sync_2ff.sv | 27 ++
 rtl/vga_scene_timing_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/vga_scene_timing_ctrl_pkg.sv
// Shared raster timing constants, widths and helpers for the VGA scene timing controller.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int SCENE_W = 2;
  localparam int AUDIO_W = 2;
  localparam int FCNT_W  = 8;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Undelayed timing flags decoded straight from the raster counters.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } raw_timing_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scene_timing_ctrl_if.sv
// Raster/timing bundle between the timing controller (master) and the pattern/audio generators.
// Request pins enter here; counters, sync strobes and committed selects leave here.
interface vga_scene_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic [SCENE_W-1:0] scene_req;
  logic [AUDIO_W-1:0] audio_req;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               line_end;
  logic               frame_end;
  logic               hsync;
  logic               vsync;
  logic               display_en;
  logic [SCENE_W-1:0] scene_sel;
  logic [AUDIO_W-1:0] audio_sel;
  logic [FCNT_W-1:0]  frame_cnt;

  modport master (
    input  scene_req, audio_req,
    output x, y, line_end, frame_end, hsync, vsync, display_en,
           scene_sel, audio_sel, frame_cnt
  );

  modport slave (
    output scene_req, audio_req,
    input  x, y, line_end, frame_end, hsync, vsync, display_en,
           scene_sel, audio_sel, frame_cnt
  );

endinterface

// File: rtl/vga_scene_timing_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; 2 clk latency, no flow control.
// Both stages reset to 0 so a freshly reset design never sees a stale request.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/vga_scene_timing_ctrl.sv
// Free-running raster timing and frame-boundary scene/audio commit for the VGA/audio datapath.
// x/y and strobes are undelayed; hsync/vsync/display_en lag by PIPE_DLY clocks; no backpressure.
module vga_scene_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_ACT = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input logic                     clk,
  input logic                     rst,
  vga_scene_timing_ctrl_if.master bus
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int REQ_W   = SCENE_W + AUDIO_W;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               line_end;
  logic               frame_end;
  raw_timing_t        raw;
  raw_timing_t        del;
  raw_timing_t        dly_q [PIPE_DLY];
  logic [REQ_W-1:0]   req_sync;
  logic [SCENE_W-1:0] scene_sel_q;
  logic [AUDIO_W-1:0] audio_sel_q;
  logic [FCNT_W-1:0]  frame_cnt_q;

  // Raster counters
  assign line_end  = (x_q == H_LAST);
  assign frame_end = line_end && (y_q == V_LAST);

  always_comb begin
    x_d = x_q + CNT_W'(1);
    y_d = y_q;
    if (line_end) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    raw    = '0;
    raw.de = (x_q < H_ACT_END) && (y_q < V_ACT_END);
    raw.hs = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    raw.vs = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
  end

  // Delay line keeps sync/enable aligned with the registered RGB of the pattern pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= raw;
      for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign del = dly_q[PIPE_DLY-1];

  sync_2ff #(
    .WIDTH (REQ_W)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({bus.scene_req, bus.audio_req}),
    .q_o (req_sync)
  );

  // Selections only move on the last pixel of a frame, so a frame never mixes two scenes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scene_sel_q <= '0;
      audio_sel_q <= '0;
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      scene_sel_q <= req_sync[REQ_W-1:AUDIO_W];
      audio_sel_q <= req_sync[AUDIO_W-1:0];
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.line_end   = line_end;
  assign bus.frame_end  = frame_end;
  assign bus.hsync      = del.hs ? SYNC_ACT : ~SYNC_ACT;
  assign bus.vsync      = del.vs ? SYNC_ACT : ~SYNC_ACT;
  assign bus.display_en = del.de;
  assign bus.scene_sel  = scene_sel_q;
  assign bus.audio_sel  = audio_sel_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
